// File: rtl/pe_accumulator.sv
// rtl/pe_accumulator.sv - windowed product accumulator with round/shift/saturate and 2-entry output FIFO
module pe_accumulator #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int TAPS         = 9,
  parameter int ACC_WIDTH    = 24,
  parameter int SHIFT        = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clear,
  input  logic [DATA_WIDTH+WEIGHT_WIDTH-1:0] prod_in,
  input  logic                               prod_valid,
  input  logic [ACC_WIDTH-1:0]               bias,
  output logic [DATA_WIDTH-1:0]              acc_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               overflow
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int CW = $clog2(TAPS);

  // Half-LSB rounding term for the final shift; zero when no shift is applied.
  localparam logic [ACC_WIDTH:0] RND = (SHIFT == 0) ? {(ACC_WIDTH+1){1'b0}}
                                     : ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic [ACC_WIDTH:0] PIX_MAX = {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINISH
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         tap_cnt;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_base;
  logic [ACC_WIDTH:0]    sum_ext;
  logic [ACC_WIDTH-1:0]  acc_nxt;
  logic [ACC_WIDTH:0]    rnd_ext;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  tail_valid;
  logic                  last_tap;
  logic                  push;
  logic                  pop;

  assign last_tap = prod_valid && (tap_cnt == CW'(TAPS - 1));
  assign pop      = out_valid && out_ready;
  assign busy     = (tap_cnt != '0);

  // Saturating add: the first tap of a window starts from bias instead of the running sum.
  always_comb begin
    acc_base = (tap_cnt == '0) ? bias : acc;
    sum_ext  = {1'b0, acc_base} + {{(ACC_WIDTH+1-PW){1'b0}}, prod_in};
    acc_nxt  = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
  end

  // Round, shift and clamp the finished window sum to pixel width.
  always_comb begin
    rnd_ext = ({1'b0, acc} + RND) >> SHIFT;
    res     = (rnd_ext > PIX_MAX) ? {DATA_WIDTH{1'b1}} : rnd_ext[DATA_WIDTH-1:0];
  end

  // Next-state logic; FINISH lasts one cycle and issues the FIFO push.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE:   if (prod_valid) state_nxt = S_ACCUM;
      S_ACCUM:  if (last_tap) state_nxt = S_FINISH;
      S_FINISH: begin
        push      = 1'b1;
        state_nxt = prod_valid ? S_ACCUM : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tap counter and accumulator; every valid product is taken unless cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_cnt <= '0;
      acc     <= '0;
    end else if (clear) begin
      tap_cnt <= '0;
      acc     <= '0;
    end else if (prod_valid) begin
      acc     <= acc_nxt;
      tap_cnt <= last_tap ? '0 : tap_cnt + CW'(1);
    end
  end

  // Two-entry output FIFO: acc_out is the head register, tail_q the second slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_out    <= '0;
      out_valid  <= 1'b0;
      tail_q     <= '0;
      tail_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      acc_out    <= '0;
      out_valid  <= 1'b0;
      tail_q     <= '0;
      tail_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        acc_out <= tail_q;
        if (push) tail_q <= res;
        else      tail_valid <= 1'b0;
      end else if (push) begin
        acc_out <= res;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        acc_out   <= res;
        out_valid <= 1'b1;
      end else if (!tail_valid) begin
        tail_q     <= res;
        tail_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// tb/tb_pe_accumulator.sv - self-checking bench for pe_accumulator against a queue-based model
module tb_pe_accumulator;

  localparam int DW   = 8;
  localparam int WW   = 8;
  localparam int TAPS = 9;
  localparam int AW   = 24;
  localparam int SH   = 4;
  localparam int PW   = DW + WW;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;
  localparam longint PIX_MAX = (64'd1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clear;
  logic [PW-1:0] prod_in;
  logic          prod_valid;
  logic [AW-1:0] bias;
  logic [DW-1:0] acc_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: window progress, running sum, and FIFO contents as a queue.
  int     m_taps;
  longint m_acc;
  longint m_q[$];
  bit     m_pend;
  longint m_pend_val;
  bit     m_ovf;
  longint m_head;

  pe_accumulator #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .TAPS(TAPS), .ACC_WIDTH(AW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .bias(bias), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint finish_val(input longint a);
    longint r;
    r = (a + ((SH > 0) ? (64'd1 << (SH - 1)) : 64'd0)) >> SH;
    return (r > PIX_MAX) ? PIX_MAX : r;
  endfunction

  task automatic model_reset();
    m_taps = 0;
    m_acc  = 0;
    m_q.delete();
    m_pend = 0;
    m_pend_val = 0;
    m_ovf  = 0;
    m_head = 0;
  endtask

  task automatic model_step();
    bit do_pop;
    if (clear) begin
      model_reset();
    end else begin
      do_pop = (m_q.size() > 0) && out_ready;
      if (do_pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < 2) m_q.push_back(m_pend_val);
        else m_ovf = 1;
      end
      m_pend = 0;
      if (prod_valid) begin
        m_acc = ((m_taps == 0) ? longint'(bias) : m_acc) + longint'(prod_in);
        if (m_acc > ACC_MAX) m_acc = ACC_MAX;
        m_taps++;
        if (m_taps == TAPS) begin
          m_taps = 0;
          m_pend = 1;
          m_pend_val = finish_val(m_acc);
        end
      end
      if (m_q.size() > 0) m_head = m_q[0];
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("acc_out", acc_out, m_head);
    chk("busy", busy, m_taps != 0);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cycle(input bit pv, input longint p, input longint b, input bit rdy, input bit clr);
    prod_valid = pv;
    prod_in    = PW'(p);
    bias       = AW'(b);
    out_ready  = rdy;
    clear      = clr;
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic window(input longint b, input longint p, input bit rdy);
    for (int i = 0; i < TAPS; i++) cycle(1'b1, p, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, rdy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got 0 expected 1");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    rstn = 1'b0; clear = 1'b0; prod_in = '0; prod_valid = 1'b0; bias = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc_out", acc_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rstn = 1'b1;

    // Nominal window
    window(0, 16, 1'b1);
    idle(1, 1'b1);
    chk("nominal_res", acc_out, 9);
    chk("nominal_vld", out_valid, 1);
    idle(1, 1'b1);
    chk("nominal_pop", out_valid, 0);

    // Rounding with bias
    window(8, 0, 1'b1);
    idle(1, 1'b1);
    chk("round_up", acc_out, 1);
    window(7, 0, 1'b1);
    idle(1, 1'b1);
    chk("round_down", acc_out, 0);

    // Saturation of the pixel and of the accumulator
    window(0, 65025, 1'b1);
    idle(1, 1'b1);
    chk("sat_pix", acc_out, 255);
    window(ACC_MAX, 1, 1'b1);
    idle(1, 1'b1);
    chk("sat_acc", acc_out, 255);
    idle(2, 1'b1);

    // Back-to-back windows with a gap inside the second
    window(0, 16, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 0, 0, 1'b1, 1'b0);
      chk("gap_busy", busy, 1);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 16, 0, 1'b1, 1'b0);
    window(0, 16, 1'b1);
    idle(2, 1'b1);

    // Backpressure: two held, third dropped
    window(0, 16, 1'b0);
    window(0, 32, 1'b0);
    window(0, 48, 1'b0);
    idle(1, 1'b0);
    chk("bp_ovf", overflow, 1);
    chk("bp_head", acc_out, 9);
    idle(1, 1'b1);
    chk("bp_drain2", acc_out, 18);
    idle(1, 1'b1);
    chk("bp_empty", out_valid, 0);

    // Full FIFO with simultaneous pop and push
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    window(0, 16, 1'b0);
    window(0, 32, 1'b0);
    window(0, 48, 1'b0);
    idle(1, 1'b1);
    chk("pp_no_ovf", overflow, 0);
    chk("pp_head", acc_out, 18);
    idle(1, 1'b1);
    chk("pp_tail", acc_out, 27);
    idle(2, 1'b1);

    // Clear together with the 5th tap
    for (int i = 0; i < 4; i++) cycle(1'b1, 16, 0, 1'b1, 1'b0);
    cycle(1'b1, 16, 0, 1'b1, 1'b1);
    chk("clr_busy", busy, 0);
    chk("clr_vld", out_valid, 0);
    window(0, 16, 1'b1);
    idle(1, 1'b1);
    chk("clr_next", acc_out, 9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit     pv, rdy, clr;
      longint p, b;
      pv  = ($urandom_range(0, 9) < 7);
      p   = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 40));
      b   = ($urandom_range(0, 3) == 0) ? longint'($urandom & 32'h00FF_FFFF) : longint'($urandom_range(0, 64));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      cycle(pv, p, b, rdy, clr);
    end

    // Asynchronous reset mid-window with every output non-zero
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    window(0, 16, 1'b0);
    window(0, 32, 1'b0);
    window(0, 48, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16, 0, 1'b0, 1'b0);
    prod_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_acc_out", acc_out, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overflow", overflow, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    window(0, 16, 1'b1);
    idle(1, 1'b1);
    chk("post_rst", acc_out, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
